// File: rtl/alu_cmd_sequencer.sv
// Command/response sequencer for the 8-bit ALU datapath: loads operands, waits
// a programmable settle time, captures result and flags, returns a response.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_hold_a,
  input  logic             cmd_chain,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [7:0]       resp_result,
  output logic             resp_zero,
  output logic             resp_carry,
  output logic [7:0]       dp_data_a,
  output logic [7:0]       dp_data_b,
  output logic [1:0]       dp_alu_op,
  output logic             dp_load_a,
  output logic             dp_load_b,
  input  logic [7:0]       dp_result,
  input  logic             dp_zero,
  input  logic             dp_carry,
  output logic             busy,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [7:0]       last_result_q, last_result_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             resp_valid_q, resp_valid_d;
  logic [7:0]       resp_result_q, resp_result_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp_carry_q, resp_carry_d;
  logic [7:0]       dp_data_a_q, dp_data_a_d;
  logic [7:0]       dp_data_b_q, dp_data_b_d;
  logic [1:0]       dp_alu_op_q, dp_alu_op_d;
  logic             dp_load_a_q, dp_load_a_d;
  logic             dp_load_b_q, dp_load_b_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;

  // Next-state and registered-output logic; dp operands/op double as the command register.
  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    last_result_d = last_result_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_carry_d  = resp_carry_q;
    dp_data_a_d   = dp_data_a_q;
    dp_data_b_d   = dp_data_b_q;
    dp_alu_op_d   = dp_alu_op_q;
    dp_load_a_d   = 1'b0;
    dp_load_b_d   = 1'b0;
    txn_cnt_d     = txn_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = S_LOAD;
          dp_load_b_d = 1'b1;
          dp_load_a_d = !cmd_hold_a;
          dp_data_a_d = cmd_chain ? last_result_q : cmd_a;
          dp_data_b_d = cmd_b;
          dp_alu_op_d = cmd_op;
        end
      end
      S_LOAD: begin
        state_d      = S_SETTLE;
        settle_cnt_d = SET_W'(SETTLE_CYCLES - 1);
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d       = S_RESP;
          resp_valid_d  = 1'b1;
          resp_result_d = dp_result;
          resp_zero_d   = dp_zero;
          resp_carry_d  = dp_carry;
          last_result_d = dp_result;
        end else begin
          settle_cnt_d = settle_cnt_q - SET_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          txn_cnt_d    = txn_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      settle_cnt_q  <= '0;
      last_result_q <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_carry_q  <= 1'b0;
      dp_data_a_q   <= '0;
      dp_data_b_q   <= '0;
      dp_alu_op_q   <= '0;
      dp_load_a_q   <= 1'b0;
      dp_load_b_q   <= 1'b0;
      txn_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      last_result_q <= last_result_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_carry_q  <= resp_carry_d;
      dp_data_a_q   <= dp_data_a_d;
      dp_data_b_q   <= dp_data_b_d;
      dp_alu_op_q   <= dp_alu_op_d;
      dp_load_a_q   <= dp_load_a_d;
      dp_load_b_q   <= dp_load_b_d;
      txn_cnt_q     <= txn_cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_carry  = resp_carry_q;
  assign dp_data_a   = dp_data_a_q;
  assign dp_data_b   = dp_data_b_q;
  assign dp_alu_op   = dp_alu_op_q;
  assign dp_load_a   = dp_load_a_q;
  assign dp_load_b   = dp_load_b_q;
  assign txn_cnt     = txn_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small ALU datapath model;
// a second instance with a 2-bit counter shares the stimulus to show wrap.
module tb_alu_cmd_sequencer;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_hold_a, cmd_chain;
  logic [1:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       resp_valid, resp_ready, resp_zero, resp_carry;
  logic [7:0] resp_result;
  logic [7:0] dp_data_a, dp_data_b, dp_result;
  logic [1:0] dp_alu_op;
  logic       dp_load_a, dp_load_b, dp_zero, dp_carry, busy;
  logic [15:0] txn_cnt;

  logic       d2_cmd_ready, d2_resp_valid, d2_resp_zero, d2_resp_carry;
  logic [7:0] d2_resp_result, d2_dp_data_a, d2_dp_data_b;
  logic [1:0] d2_dp_alu_op;
  logic       d2_dp_load_a, d2_dp_load_b, d2_busy;
  logic [1:0] d2_txn_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_hold_a(cmd_hold_a), .cmd_chain(cmd_chain),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_carry(resp_carry),
    .dp_data_a(dp_data_a), .dp_data_b(dp_data_b), .dp_alu_op(dp_alu_op),
    .dp_load_a(dp_load_a), .dp_load_b(dp_load_b),
    .dp_result(dp_result), .dp_zero(dp_zero), .dp_carry(dp_carry),
    .busy(busy), .txn_cnt(txn_cnt)
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_hold_a(cmd_hold_a), .cmd_chain(cmd_chain),
    .resp_valid(d2_resp_valid), .resp_ready(resp_ready), .resp_result(d2_resp_result),
    .resp_zero(d2_resp_zero), .resp_carry(d2_resp_carry),
    .dp_data_a(d2_dp_data_a), .dp_data_b(d2_dp_data_b), .dp_alu_op(d2_dp_alu_op),
    .dp_load_a(d2_dp_load_a), .dp_load_b(d2_dp_load_b),
    .dp_result(dp_result), .dp_zero(dp_zero), .dp_carry(dp_carry),
    .busy(d2_busy), .txn_cnt(d2_txn_cnt)
  );

  // Datapath model: operand registers plus combinational ALU (add/sub/and/or).
  logic [7:0] a_reg, b_reg;
  logic [8:0] alu_full;
  always_ff @(posedge clk) begin
    if (dp_load_a) a_reg <= dp_data_a;
    if (dp_load_b) b_reg <= dp_data_b;
  end
  always_comb begin
    alu_full = '0;
    case (dp_alu_op)
      2'b00: alu_full = {1'b0, a_reg} + {1'b0, b_reg};
      2'b01: alu_full = {1'b0, a_reg} - {1'b0, b_reg};
      2'b10: alu_full = {1'b0, a_reg & b_reg};
      default: alu_full = {1'b0, a_reg | b_reg};
    endcase
  end
  assign dp_result = alu_full[7:0];
  assign dp_carry  = alu_full[8];
  assign dp_zero   = (alu_full[7:0] == 8'h00);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command from IDLE; after accept edge T, check the LOAD cycle.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic hold, input logic chain, input logic [7:0] exp_da);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_hold_a = hold; cmd_chain = chain;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("load_b_in_load", 32'(dp_load_b), 32'd1);
    chk("load_a_in_load", 32'(dp_load_a), 32'(!hold));
    chk("data_a_in_load", 32'(dp_data_a), 32'(exp_da));
    chk("data_b_in_load", 32'(dp_data_b), 32'(b));
    chk("op_in_load", 32'(dp_alu_op), 32'(op));
    chk("cmd_ready_in_load", 32'(cmd_ready), 32'd0);
    chk("busy_in_load", 32'(busy), 32'd1);
  endtask

  // SETTLE at T+1 (no response yet), response at T+2.
  task automatic settle;
    @(posedge clk); #1;
    chk("loads_in_settle", 32'({dp_load_a, dp_load_b}), 32'd0);
    chk("resp_valid_t1", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("resp_valid_t2", 32'(resp_valid), 32'd1);
  endtask

  task automatic take(input logic [7:0] r, input logic z, input logic c, input logic [15:0] cnt);
    chk("resp_result", 32'(resp_result), 32'(r));
    chk("resp_zero", 32'(resp_zero), 32'(z));
    chk("resp_carry", 32'(resp_carry), 32'(c));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_valid_cleared", 32'(resp_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("txn_cnt", 32'(txn_cnt), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_hold_a = 1'b0; cmd_chain = 1'b0; resp_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_loads", 32'({dp_load_a, dp_load_b}), 32'd0);
    chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    chk("rst_op", 32'(dp_alu_op), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Add 0F+01
    issue(2'b00, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h0F);
    settle();
    take(8'h10, 1'b0, 1'b0, 16'd1);

    // Chain from last result 10: 10+05
    issue(2'b00, 8'hAA, 8'h05, 1'b0, 1'b1, 8'h10);
    settle();
    take(8'h15, 1'b0, 1'b0, 16'd2);

    // Carry: FF+01
    issue(2'b00, 8'hFF, 8'h01, 1'b0, 1'b0, 8'hFF);
    settle();
    take(8'h00, 1'b1, 1'b1, 16'd3);

    // AND, then op must persist in IDLE
    issue(2'b10, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'hF0);
    settle();
    take(8'h30, 1'b0, 1'b0, 16'd4);
    chk("op_held_in_idle", 32'(dp_alu_op), 32'd2);

    // Backpressure with OR 12|21 and cmd_valid held high
    issue(2'b11, 8'h12, 8'h21, 1'b0, 1'b0, 8'h12);
    settle();
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_result", 32'(resp_result), 32'h33);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_txn_cnt", 32'(txn_cnt), 32'd4);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; cmd_valid = 1'b0;
    chk("bp_handshake_cnt", 32'(txn_cnt), 32'd5);
    chk("bp_handshake_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp_no_new_cmd", 32'(busy), 32'd0);

    // Hold A (plus chain: hold wins): datapath A stays 12, 12+01
    issue(2'b00, 8'h99, 8'h01, 1'b1, 1'b1, 8'h33);
    settle();
    take(8'h13, 1'b0, 1'b0, 16'd6);

    // Reset in SETTLE
    issue(2'b00, 8'h01, 8'h02, 1'b0, 1'b0, 8'h01);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_loads", 32'({dp_load_a, dp_load_b}), 32'd0);
    chk("midrst_txn_cnt", 32'(txn_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_resp_valid", 32'(resp_valid), 32'd0);

    // Chain right after reset uses last_result=0: 00+05
    issue(2'b00, 8'h77, 8'h05, 1'b0, 1'b1, 8'h00);
    settle();
    take(8'h05, 1'b0, 1'b0, 16'd1);
    for (int i = 0; i < 4; i++) begin
      issue(2'b00, 8'(i + 1), 8'h01, 1'b0, 1'b0, 8'(i + 1));
      settle();
      take(8'(i + 2), 1'b0, 1'b0, 16'(i + 2));
    end
    chk("wrap_txn_cnt_w2", 32'(d2_txn_cnt), 32'd1);
    chk("txn_cnt_w16", 32'(txn_cnt), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
